alu_multicycle: RTL

//  Parametrised successor to the 3-bit-opcode datapath ALU. Adds a W-bit datapath, a persistent

---
 rtl/alu_multicycle.sv | 186 ++++++++++++++++++
 1 files changed

// File: rtl/alu_multicycle.sv
// Multi-cycle W-bit ALU with persistent flag and fill-mode shifts; ALU_BARREL_SHIFT_EN makes shifts single-cycle.
// Latency: 1 cycle for non-shifts and shamt 0, 1+shamt for iterative shifts (1 for all ops when barrel).
// Backpressure: result held in HOLD until out_ready; in_ready drops while shifting or while a result is stalled.
module alu_multicycle #(
  parameter int W    = 8,
  parameter int SA_W = $clog2(W)
) (
  input  logic            clk,
  input  logic            reset_n,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [2:0]      op,
  input  logic [1:0]      fill,
  input  logic [W-1:0]    a,
  input  logic [W-1:0]    b,
  input  logic [SA_W-1:0] shamt,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [W-1:0]    res,
  output logic            flag_o,
  output logic            busy
);

  localparam logic [2:0] OP_ADD = 3'b000;
  localparam logic [2:0] OP_SUB = 3'b001;
  localparam logic [2:0] OP_CEQ = 3'b010;
  localparam logic [2:0] OP_CLT = 3'b011;
  localparam logic [2:0] OP_XOR = 3'b100;
  localparam logic [2:0] OP_AND = 3'b101;

  typedef enum logic [1:0] {IDLE, SHIFT, HOLD} state_t;

  state_t         state, nextState;
  logic           accept;
  logic           isShift;
  logic           startShift;
  logic [W-1:0]   aluRes;
  logic           aluFlag;
  logic [W:0]     sum;

  // One shift step: returns {bit shifted out, shifted value}.
  function automatic logic [W:0] shiftStep(input logic [W-1:0] v, input logic left,
                                           input logic [1:0] f, input logic fl);
    logic o;
    logic fb;
    o = left ? v[W-1] : v[0];
    case (f)
      2'b00:   fb = 1'b0;
      2'b01:   fb = 1'b1;
      2'b10:   fb = fl;
      default: fb = o;
    endcase
    shiftStep = left ? {o, v[W-2:0], fb} : {o, fb, v[W-1:1]};
  endfunction

  assign isShift = op[2] & op[1];
  assign accept  = in_valid & in_ready;
  assign sum     = {1'b0, a} + {1'b0, b};

`ifdef ALU_BARREL_SHIFT_EN
  // Unrolled chain of single steps so flag and fill behave exactly like the iterative path.
  function automatic logic [W:0] shiftAll(input logic [W-1:0] v, input logic [SA_W-1:0] amt,
                                          input logic left, input logic [1:0] f, input logic fl);
    logic [W:0] t;
    t = {fl, v};
    for (int i = 0; i < W; i++) begin
      if (i < int'(amt)) t = shiftStep(t[W-1:0], left, f, fl);
    end
    shiftAll = t;
  endfunction

  assign startShift = 1'b0;
`else
  logic [W-1:0]   shReg;
  logic [SA_W-1:0] cnt;
  logic           leftL;
  logic [1:0]     fillL;
  logic           flagL;
  logic [W:0]     stepOut;

  assign startShift = isShift & (shamt != '0);
  assign stepOut    = shiftStep(shReg, leftL, fillL, flagL);
`endif

  always_comb begin
    aluRes  = a;
    aluFlag = flag_o;
    case (op)
      OP_ADD: {aluFlag, aluRes} = sum;
      OP_SUB: begin
        aluRes  = a - b;
        aluFlag = (a < b);
      end
      OP_CEQ: begin
        aluRes  = {{(W-1){1'b0}}, a == b};
        aluFlag = (a == b);
      end
      OP_CLT: begin
        aluRes  = {{(W-1){1'b0}}, $signed(a) < $signed(b)};
        aluFlag = ($signed(a) < $signed(b));
      end
      OP_XOR: aluRes = a ^ b;
      OP_AND: aluRes = a & b;
      default: begin
`ifdef ALU_BARREL_SHIFT_EN
        {aluFlag, aluRes} = shiftAll(a, shamt, ~op[0], fill, flag_o);
`else
        aluRes  = a;
        aluFlag = flag_o;
`endif
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset_n) state <= IDLE;
    else          state <= nextState;
  end

  always_comb begin
    nextState = state;
    case (state)
      IDLE: if (accept) nextState = startShift ? SHIFT : HOLD;
      SHIFT: begin
`ifdef ALU_BARREL_SHIFT_EN
        nextState = HOLD;
`else
        if (cnt == SA_W'(1)) nextState = HOLD;
`endif
      end
      HOLD: begin
        if (accept)         nextState = startShift ? SHIFT : HOLD;
        else if (out_ready) nextState = IDLE;
      end
      default: nextState = IDLE;
    endcase
  end

  always_comb begin
    in_ready  = reset_n & ((state == IDLE) | ((state == HOLD) & out_ready));
    out_valid = (state == HOLD);
`ifdef ALU_BARREL_SHIFT_EN
    busy      = 1'b0;
`else
    busy      = (state == SHIFT);
`endif
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      res    <= '0;
      flag_o <= 1'b0;
`ifndef ALU_BARREL_SHIFT_EN
      shReg  <= '0;
      cnt    <= '0;
      leftL  <= 1'b0;
      fillL  <= 2'b00;
      flagL  <= 1'b0;
`endif
    end else if (accept) begin
`ifdef ALU_BARREL_SHIFT_EN
      res    <= aluRes;
      flag_o <= aluFlag;
`else
      if (startShift) begin
        shReg <= a;
        cnt   <= shamt;
        leftL <= ~op[0];
        fillL <= fill;
        flagL <= flag_o;
      end else begin
        res    <= aluRes;
        flag_o <= aluFlag;
      end
`endif
    end
`ifndef ALU_BARREL_SHIFT_EN
    else if (state == SHIFT) begin
      shReg <= stepOut[W-1:0];
      cnt   <= cnt - SA_W'(1);
      if (cnt == SA_W'(1)) {flag_o, res} <= stepOut;
    end
`endif
  end

endmodule
